// File: rtl/load_store_unit_pkg.sv
// +----------------------------------------------------------------------------+
// | load_store_unit_pkg : opcodes, funct3 codes, FSM encoding, size helpers   |
// | Revision 1.0                                                               |
// +----------------------------------------------------------------------------+
`default_nettype none

package load_store_unit_pkg;

  localparam logic [6:0] OPC_LOAD  = 7'b0000011;
  localparam logic [6:0] OPC_STORE = 7'b0100011;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_ACCESS  = 2'd1;
  localparam logic [1:0] ST_ACCESS2 = 2'd2;
  localparam logic [1:0] ST_RESP    = 2'd3;

  typedef enum logic [1:0] {SZ_B, SZ_H, SZ_W} lsu_size_e;

  // Reserved funct3 encodings fall through to word accesses.
  function automatic lsu_size_e size_of(input logic [2:0] f3);
    case (f3)
      F3_B, F3_BU: return SZ_B;
      F3_H, F3_HU: return SZ_H;
      F3_W:        return SZ_W;
      default:     return SZ_W;
    endcase
  endfunction

  function automatic logic [3:0] base_strobe(input lsu_size_e sz);
    case (sz)
      SZ_B:    return 4'b0001;
      SZ_H:    return 4'b0011;
      default: return 4'b1111;
    endcase
  endfunction

  function automatic logic is_misaligned(input lsu_size_e sz, input logic [1:0] off);
    case (sz)
      SZ_B:    return 1'b0;
      SZ_H:    return off[0];
      default: return |off;
    endcase
  endfunction

endpackage

`default_nettype wire

// File: rtl/load_store_unit_if.sv
// +----------------------------------------------------------------------------+
// | load_store_unit_if : request, memory-bus and response signals of the LSU  |
// | Revision 1.0                                                               |
// +----------------------------------------------------------------------------+
`default_nettype none

interface load_store_unit_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
);
  logic                    req_valid;
  logic                    req_ready;
  logic [6:0]              opcode;
  logic [2:0]              funct3;
  logic [ADDR_WIDTH-1:0]   address;
  logic [DATA_WIDTH-1:0]   store_data;
  logic                    mem_valid;
  logic                    mem_ready;
  logic                    mem_we;
  logic [ADDR_WIDTH-1:0]   mem_addr;
  logic [DATA_WIDTH/8-1:0] mem_wstrb;
  logic [DATA_WIDTH-1:0]   mem_wdata;
  logic [DATA_WIDTH-1:0]   mem_rdata;
  logic                    resp_valid;
  logic [DATA_WIDTH-1:0]   load_data;
  logic                    misaligned;

  modport master (
    input  req_valid, opcode, funct3, address, store_data, mem_ready, mem_rdata,
    output req_ready, mem_valid, mem_we, mem_addr, mem_wstrb, mem_wdata,
           resp_valid, load_data, misaligned
  );

  modport slave (
    output req_valid, opcode, funct3, address, store_data, mem_ready, mem_rdata,
    input  req_ready, mem_valid, mem_we, mem_addr, mem_wstrb, mem_wdata,
           resp_valid, load_data, misaligned
  );
endinterface

`default_nettype wire

// File: rtl/lsu_data_align.sv
// +----------------------------------------------------------------------------+
// | lsu_data_align : store lane shift/strobes and load extraction/extension   |
// | Revision 1.0                                                               |
// +----------------------------------------------------------------------------+
`default_nettype none

module lsu_data_align
  import load_store_unit_pkg::*;
(
  input  logic [2:0]  st_funct3,
  input  logic [1:0]  st_offset,
  input  logic [31:0] st_data,
  output logic [3:0]  st_strb_lo,
  output logic [3:0]  st_strb_hi,
  output logic [31:0] st_wdata_lo,
  output logic [31:0] st_wdata_hi,
  output logic        st_misaligned,
  input  logic [2:0]  ld_funct3,
  input  logic [1:0]  ld_offset,
  input  logic [31:0] ld_rdata_lo,
  input  logic [31:0] ld_rdata_hi,
  output logic [31:0] ld_data
);
  lsu_size_e   st_size;
  lsu_size_e   ld_size;
  logic [7:0]  strb_wide;
  logic [63:0] wdata_wide;
  logic [31:0] ld_shifted;
  logic        ld_signed;

  always_comb begin
    st_size       = size_of(st_funct3);
    strb_wide     = {4'b0000, base_strobe(st_size)} << st_offset;
    wdata_wide    = {32'd0, st_data} << {st_offset, 3'b000};
    st_misaligned = is_misaligned(st_size, st_offset);
    st_strb_lo    = strb_wide[3:0];
    st_strb_hi    = strb_wide[7:4];
    st_wdata_hi   = wdata_wide[63:32];
    case (st_size)
      SZ_B:    st_wdata_lo = {4{st_data[7:0]}};
      SZ_H:    st_wdata_lo = {2{st_data[15:0]}};
      default: st_wdata_lo = st_data;
    endcase
    // A split access needs the shifted form so each beat carries its own lanes.
    if (st_misaligned) st_wdata_lo = wdata_wide[31:0];
  end

  always_comb begin
    ld_size    = size_of(ld_funct3);
    ld_signed  = ~ld_funct3[2];
    ld_shifted = 32'({ld_rdata_hi, ld_rdata_lo} >> {ld_offset, 3'b000});
    case (ld_size)
      SZ_B:    ld_data = {{24{ld_signed & ld_shifted[7]}}, ld_shifted[7:0]};
      SZ_H:    ld_data = {{16{ld_signed & ld_shifted[15]}}, ld_shifted[15:0]};
      default: ld_data = ld_shifted;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/load_store_unit.sv
// +----------------------------------------------------------------------------+
// | load_store_unit : memory-access stage FSM; MISALIGNED_SPLIT_EN splits     |
// | misaligned H/W into two beats. Revision 1.0                                |
// +----------------------------------------------------------------------------+
`default_nettype none

module load_store_unit
  import load_store_unit_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
) (
  input  logic               clk,
  input  logic               reset,
  load_store_unit_if.master  lsu
);
  logic [1:0]            state_q, state_d;
  logic                  is_store_q, is_store_d;
  logic [2:0]            funct3_q, funct3_d;
  logic [1:0]            offset_q, offset_d;
  logic                  misaligned_q, misaligned_d;
  logic                  mem_valid_q, mem_valid_d;
  logic                  mem_we_q, mem_we_d;
  logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic [3:0]            mem_wstrb_q, mem_wstrb_d;
  logic [DATA_WIDTH-1:0] mem_wdata_q, mem_wdata_d;
  logic [DATA_WIDTH-1:0] rdata_lo_q, rdata_lo_d;

  logic [3:0]            st_strb_lo, st_strb_hi;
  logic [31:0]           st_wdata_lo, st_wdata_hi;
  logic                  st_mis;
  logic [31:0]           ld_data;
  logic [31:0]           ld_rdata_hi;

`ifdef MISALIGNED_SPLIT_EN
  logic                  split_q, split_d;
  logic [3:0]            strb_hi_q, strb_hi_d;
  logic [31:0]           wdata_hi_q, wdata_hi_d;
  logic [31:0]           rdata_hi_q, rdata_hi_d;
  assign ld_rdata_hi = rdata_hi_q;
`else
  logic                  unused_split;
  assign unused_split = ^{st_strb_hi, st_wdata_hi};
  assign ld_rdata_hi  = 32'd0;
`endif

  lsu_data_align u_align (
    .st_funct3     (lsu.funct3),
    .st_offset     (lsu.address[1:0]),
    .st_data       (lsu.store_data),
    .st_strb_lo    (st_strb_lo),
    .st_strb_hi    (st_strb_hi),
    .st_wdata_lo   (st_wdata_lo),
    .st_wdata_hi   (st_wdata_hi),
    .st_misaligned (st_mis),
    .ld_funct3     (funct3_q),
    .ld_offset     (offset_q),
    .ld_rdata_lo   (rdata_lo_q),
    .ld_rdata_hi   (ld_rdata_hi),
    .ld_data       (ld_data)
  );

  always_comb begin
    state_d      = state_q;
    is_store_d   = is_store_q;
    funct3_d     = funct3_q;
    offset_d     = offset_q;
    misaligned_d = misaligned_q;
    mem_valid_d  = mem_valid_q;
    mem_we_d     = mem_we_q;
    mem_addr_d   = mem_addr_q;
    mem_wstrb_d  = mem_wstrb_q;
    mem_wdata_d  = mem_wdata_q;
    rdata_lo_d   = rdata_lo_q;
`ifdef MISALIGNED_SPLIT_EN
    split_d      = split_q;
    strb_hi_d    = strb_hi_q;
    wdata_hi_d   = wdata_hi_q;
    rdata_hi_d   = rdata_hi_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (lsu.req_valid && (lsu.opcode == OPC_LOAD || lsu.opcode == OPC_STORE)) begin
          is_store_d  = (lsu.opcode == OPC_STORE);
          funct3_d    = lsu.funct3;
          offset_d    = lsu.address[1:0];
          mem_addr_d  = {lsu.address[ADDR_WIDTH-1:2], 2'b00};
          mem_we_d    = (lsu.opcode == OPC_STORE);
          mem_wstrb_d = st_strb_lo;
          mem_wdata_d = st_wdata_lo;
`ifdef MISALIGNED_SPLIT_EN
          misaligned_d = 1'b0;
          split_d      = st_mis;
          strb_hi_d    = st_strb_hi;
          wdata_hi_d   = st_wdata_hi;
          mem_valid_d  = 1'b1;
          state_d      = ST_ACCESS;
`else
          misaligned_d = st_mis;
          mem_valid_d  = ~st_mis;
          state_d      = st_mis ? ST_RESP : ST_ACCESS;
`endif
        end
      end
      ST_ACCESS: begin
        if (lsu.mem_ready) begin
          rdata_lo_d  = lsu.mem_rdata;
          mem_valid_d = 1'b0;
          state_d     = ST_RESP;
`ifdef MISALIGNED_SPLIT_EN
          // Second beat targets the next word; address wraps naturally.
          if (split_q) begin
            mem_valid_d = 1'b1;
            mem_addr_d  = mem_addr_q + ADDR_WIDTH'(4);
            mem_wstrb_d = strb_hi_q;
            mem_wdata_d = wdata_hi_q;
            state_d     = ST_ACCESS2;
          end
`endif
        end
      end
`ifdef MISALIGNED_SPLIT_EN
      ST_ACCESS2: begin
        if (lsu.mem_ready) begin
          rdata_hi_d  = lsu.mem_rdata;
          mem_valid_d = 1'b0;
          state_d     = ST_RESP;
        end
      end
`endif
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= ST_IDLE;
      is_store_q   <= 1'b0;
      funct3_q     <= 3'd0;
      offset_q     <= 2'd0;
      misaligned_q <= 1'b0;
      mem_valid_q  <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wstrb_q  <= 4'd0;
      mem_wdata_q  <= '0;
      rdata_lo_q   <= '0;
`ifdef MISALIGNED_SPLIT_EN
      split_q      <= 1'b0;
      strb_hi_q    <= 4'd0;
      wdata_hi_q   <= 32'd0;
      rdata_hi_q   <= 32'd0;
`endif
    end else begin
      state_q      <= state_d;
      is_store_q   <= is_store_d;
      funct3_q     <= funct3_d;
      offset_q     <= offset_d;
      misaligned_q <= misaligned_d;
      mem_valid_q  <= mem_valid_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_wstrb_q  <= mem_wstrb_d;
      mem_wdata_q  <= mem_wdata_d;
      rdata_lo_q   <= rdata_lo_d;
`ifdef MISALIGNED_SPLIT_EN
      split_q      <= split_d;
      strb_hi_q    <= strb_hi_d;
      wdata_hi_q   <= wdata_hi_d;
      rdata_hi_q   <= rdata_hi_d;
`endif
    end
  end

  assign lsu.req_ready  = (state_q == ST_IDLE);
  assign lsu.mem_valid  = mem_valid_q;
  assign lsu.mem_we     = mem_we_q;
  assign lsu.mem_addr   = mem_addr_q;
  assign lsu.mem_wstrb  = mem_wstrb_q;
  assign lsu.mem_wdata  = mem_wdata_q;
  assign lsu.resp_valid = (state_q == ST_RESP);
  assign lsu.misaligned = (state_q == ST_RESP) && misaligned_q;
  assign lsu.load_data  = (state_q == ST_RESP && !is_store_q && !misaligned_q) ? ld_data : '0;

endmodule

`default_nettype wire

// File: tb/tb_load_store_unit.sv
// +----------------------------------------------------------------------------+
// | tb_load_store_unit : randomized bench with a byte-level reference model   |
// | Revision 1.0                                                               |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_load_store_unit;
  localparam logic [6:0] T_LOAD  = 7'h03;
  localparam logic [6:0] T_STORE = 7'h23;

  logic clk = 1'b0;
  logic reset;
  int   vectors     = 0;
  int   miscompares = 0;

  always #5 clk = ~clk;

  load_store_unit_if bus ();

  load_store_unit dut (
    .clk   (clk),
    .reset (reset),
    .lsu   (bus)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: observed %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // Byte-granular model: each request byte lands at address a+i, split into words.
  task automatic run_txn(input logic [6:0] op, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] sd, input logic [31:0] rd0, input logic [31:0] rd1,
                         input int st0, input int st1, input bit hold);
    int          size, nbeats, k, lane;
    bit          uns, mis, split, is_st;
    logic [31:0] e_addr[2];
    logic [31:0] e_wd[2];
    logic [3:0]  e_strb[2];
    logic [31:0] rd[2];
    int          st[2];
    logic [31:0] e_ld, b;

    is_st = (op == T_STORE);
    case (f3)
      3'b000, 3'b100: size = 1;
      3'b001, 3'b101: size = 2;
      default:        size = 4;
    endcase
    uns    = (f3 == 3'b100) || (f3 == 3'b101);
    mis    = (int'(a[1:0]) % size) != 0;
    split  = 1'b0;
    nbeats = 1;
    if (mis) begin
`ifdef MISALIGNED_SPLIT_EN
      nbeats = 2;
      split  = 1'b1;
`else
      nbeats = 0;
`endif
    end
    rd[0] = rd0; rd[1] = rd1; st[0] = st0; st[1] = st1;
    e_addr[0] = a & ~32'd3;
    e_addr[1] = e_addr[0] + 32'd4;
    e_strb[0] = 4'd0; e_strb[1] = 4'd0;
    e_wd[0] = 32'd0; e_wd[1] = 32'd0;
    e_ld = 32'd0;
    for (int i = 0; i < size; i++) begin
      b    = a + 32'(i);
      k    = ((b & ~32'd3) != e_addr[0]) ? 1 : 0;
      lane = int'(b[1:0]);
      e_strb[k][lane] = 1'b1;
      if (split) e_wd[k][lane*8 +: 8] = sd[i*8 +: 8];
      e_ld[i*8 +: 8] = rd[k][lane*8 +: 8];
    end
    if (!split)
      for (int l = 0; l < 4; l++) e_wd[0][l*8 +: 8] = sd[(l % size)*8 +: 8];
    if (!uns && size < 4 && e_ld[size*8-1])
      for (int j = size; j < 4; j++) e_ld[j*8 +: 8] = 8'hFF;
    if (is_st || nbeats == 0) e_ld = 32'd0;

    bus.req_valid  = 1'b1;
    bus.opcode     = op;
    bus.funct3     = f3;
    bus.address    = a;
    bus.store_data = sd;
    check("req_ready_idle", {31'd0, bus.req_ready}, 32'd1);
    @(negedge clk);
    if (!hold) bus.req_valid = 1'b0;

    for (int kb = 0; kb < nbeats; kb++) begin
      for (int c = 0; c <= st[kb]; c++) begin
        check("mem_valid", {31'd0, bus.mem_valid}, 32'd1);
        check("mem_addr", bus.mem_addr, e_addr[kb]);
        check("mem_wstrb", {28'd0, bus.mem_wstrb}, {28'd0, e_strb[kb]});
        check("mem_we", {31'd0, bus.mem_we}, {31'd0, is_st});
        if (is_st) check("mem_wdata", bus.mem_wdata, e_wd[kb]);
        check("req_ready_busy", {31'd0, bus.req_ready}, 32'd0);
        check("resp_early", {31'd0, bus.resp_valid}, 32'd0);
        bus.mem_ready = (c == st[kb]);
        bus.mem_rdata = (c == st[kb]) ? rd[kb] : $urandom;
        @(negedge clk);
        bus.mem_ready = 1'b0;
      end
    end

    check("resp_valid", {31'd0, bus.resp_valid}, 32'd1);
    check("misaligned", {31'd0, bus.misaligned}, {31'd0, (nbeats == 0)});
    check("load_data", bus.load_data, e_ld);
    check("mem_valid_resp", {31'd0, bus.mem_valid}, 32'd0);
    check("req_ready_resp", {31'd0, bus.req_ready}, 32'd0);
    @(negedge clk);
    check("resp_pulse", {31'd0, bus.resp_valid}, 32'd0);
    check("req_ready_back", {31'd0, bus.req_ready}, 32'd1);
  endtask

  initial begin
    logic [2:0] f3;
    reset          = 1'b0;
    bus.req_valid  = 1'b0;
    bus.opcode     = 7'd0;
    bus.funct3     = 3'd0;
    bus.address    = 32'd0;
    bus.store_data = 32'd0;
    bus.mem_ready  = 1'b0;
    bus.mem_rdata  = 32'd0;
    repeat (2) @(negedge clk);
    check("rst_req_ready", {31'd0, bus.req_ready}, 32'd1);
    check("rst_mem_valid", {31'd0, bus.mem_valid}, 32'd0);
    check("rst_mem_we", {31'd0, bus.mem_we}, 32'd0);
    check("rst_mem_addr", bus.mem_addr, 32'd0);
    check("rst_mem_wstrb", {28'd0, bus.mem_wstrb}, 32'd0);
    check("rst_mem_wdata", bus.mem_wdata, 32'd0);
    check("rst_resp_valid", {31'd0, bus.resp_valid}, 32'd0);
    check("rst_load_data", bus.load_data, 32'd0);
    check("rst_misaligned", {31'd0, bus.misaligned}, 32'd0);
    reset = 1'b1;
    @(negedge clk);

    run_txn(T_LOAD,  3'b010, 32'h0000_1000, 32'd0, 32'hDEAD_BEEF, 32'd0, 0, 0, 0);
    run_txn(T_LOAD,  3'b000, 32'h0000_1003, 32'd0, 32'h80FF_FF00, 32'd0, 0, 0, 0);
    run_txn(T_LOAD,  3'b100, 32'h0000_1003, 32'd0, 32'h80FF_FF00, 32'd0, 1, 0, 0);
    run_txn(T_LOAD,  3'b101, 32'h0000_1002, 32'd0, 32'h80FF_FF00, 32'd0, 0, 0, 0);
    run_txn(T_STORE, 3'b000, 32'h0000_2001, 32'h1234_5678, 32'd0, 32'd0, 3, 0, 0);
    run_txn(T_STORE, 3'b010, 32'h0000_2002, 32'h1234_5678, 32'd0, 32'd0, 1, 2, 0);
    run_txn(T_LOAD,  3'b001, 32'hFFFF_FFFF, 32'd0, 32'h1234_5678, 32'h9ABC_DEF0, 0, 1, 0);
    run_txn(T_LOAD,  3'b111, 32'h0000_3000, 32'd0, 32'hCAFE_F00D, 32'd0, 0, 0, 0);

    // Unrecognised opcode must not start a transaction.
    bus.req_valid = 1'b1;
    bus.opcode    = 7'h13;
    @(negedge clk);
    check("badop_ready", {31'd0, bus.req_ready}, 32'd1);
    check("badop_mem_valid", {31'd0, bus.mem_valid}, 32'd0);
    check("badop_resp", {31'd0, bus.resp_valid}, 32'd0);
    bus.req_valid = 1'b0;

    // Reset in the middle of a stalled access.
    bus.req_valid = 1'b1;
    bus.opcode    = T_LOAD;
    bus.funct3    = 3'b010;
    bus.address   = 32'h0000_4000;
    @(negedge clk);
    bus.req_valid = 1'b0;
    check("abort_pre_valid", {31'd0, bus.mem_valid}, 32'd1);
    reset = 1'b0;
    @(negedge clk);
    check("abort_mem_valid", {31'd0, bus.mem_valid}, 32'd0);
    check("abort_req_ready", {31'd0, bus.req_ready}, 32'd1);
    check("abort_resp", {31'd0, bus.resp_valid}, 32'd0);
    check("abort_mem_addr", bus.mem_addr, 32'd0);
    reset = 1'b1;
    @(negedge clk);
    check("abort_no_resp", {31'd0, bus.resp_valid}, 32'd0);
    run_txn(T_STORE, 3'b001, 32'h0000_5002, 32'hAAAA_BEEF, 32'd0, 32'd0, 1, 0, 0);

    // Back-to-back with req_valid held high across the first transaction.
    run_txn(T_STORE, 3'b010, 32'h0000_6000, 32'h0102_0304, 32'd0, 32'd0, 2, 0, 1);
    run_txn(T_LOAD,  3'b000, 32'h0000_6001, 32'd0, 32'h0000_F100, 32'd0, 0, 0, 0);

    for (int n = 0; n < 300; n++) begin
      f3 = 3'($urandom_range(0, 7));
      run_txn(($urandom_range(0, 1) != 0) ? T_STORE : T_LOAD, f3, $urandom, $urandom,
              $urandom, $urandom, $urandom_range(0, 3), $urandom_range(0, 3),
              (n != 299) && ($urandom_range(0, 3) == 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire
